ghost_sprite_scheduler: RTL and testbench
=========================================

Name: ghost_sprite_scheduler

Overview:
- Shares one combinational ghost bitmap ROM (anim, direction, 4-bit row, 4-bit column -> 1 pixel bit) between NUM_SPRITES ghosts.
- During horizontal blank it fetches the next scanline's 16-pixel row for each ghost into per-ghost line buffers.
- During active video it outputs the prioritised ghost pixel.
- Sits between the video sync generator / game logic and the ghost bitmap.

Parameters:
- NUM_SPRITES, 4, number of ghosts sharing the bitmap (1..4).
- ANIM_FRAMES, 8, frame_start pulses between animation-state toggles (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- hpos  in  9  current pixel column
- vpos  in  9  current scanline
- line_start  in  1  one-cycle pulse at start of hblank of line vpos
- frame_start  in  1  one-cycle pulse at start of vblank
- sprite_x  in  8*NUM_SPRITES  packed left-edge columns; sprite i in [8i+7:8i]
- sprite_y  in  8*NUM_SPRITES  packed top-row scanlines
- sprite_dir  in  2*NUM_SPRITES  packed directions
- bm_anim  out  1  to bitmap animState
- bm_dir  out  2  to bitmap direction
- bm_yin  out  4  to bitmap row
- bm_xin  out  4  to bitmap column
- bm_bit  in  1  bitmap pixel, valid in the same cycle as the address
- pix_on  out  1  ghost pixel present (registered)
- pix_id  out  2  index of the winning ghost (registered)
- busy  out  1  fetch in progress
- overrun  out  1  one-cycle pulse when a fetch is aborted by line_start
- collision  out  1  see Optional Feature

Behaviour:
- Reset (async): FSM=IDLE; line buffers, valid flags, anim, bm_* outputs, pix_on, pix_id, busy, overrun and collision all 0; anim counter 0.
- Animation:
  - Counter increments on frame_start.
  - On reaching ANIM_FRAMES-1 with frame_start, the counter wraps to 0 and anim toggles.
  - bm_anim = anim.
- Fetch line: on line_start, latch fline = vpos+1 (9-bit wrap), clear all valid flags, set index i=0, go to CHECK.
- CHECK (1 cycle), for sprite i:
  - dy = fline - {1'b0,y_i}, 9-bit.
  - Hit iff fline >= y_i and dy < 16. On hit, go to FETCH with col=0; otherwise go to NEXT.
- FETCH (16 cycles):
  - bm_dir = dir_i, bm_yin = dy[3:0], bm_xin = col.
  - Each cycle, linebuf[i][col] <= bm_bit; col increments.
  - After col=15: set valid_i and go to NEXT.
- NEXT:
  - If i = NUM_SPRITES-1, go to IDLE.
  - Otherwise i++ and go to CHECK.
- busy = 1 in every state except IDLE.
- Worst-case fetch time is NUM_SPRITES*17 + 1 cycles (69 for the default). The hblank interval must be at least this long.
- line_start while busy:
  - Abort the fetch and pulse overrun.
  - Restart from i=0 with the new fline. Buffers of unfinished sprites stay invalid.
- Display, each cycle:
  - dx_i = hpos - {1'b0,x_i}, 9-bit.
  - Ghost i is on iff valid_i, hpos >= x_i, dx_i < 16, and linebuf[i][dx_i[3:0]] = 1.
  - Lowest index wins.
  - pix_on / pix_id are registered: they reflect the hpos presented one cycle earlier.
  - pix_id = 0 when pix_on = 0.
- busy does not gate display. Software keeps line_start aligned to hblank so buffers are stable during active video.
- Ghost partially past column 255: columns up to 255+15 display normally, since hpos is 9-bit.
- frame_start and line_start in the same cycle: both take effect independently.

Optional Feature:
- Macro: SPRITE_COLLISION_EN.
- Defined:
  - collision is a sticky register, set when two or more ghosts are on at the same hpos during display.
  - frame_start clears it. If frame_start and a collision coincide, the set wins.
- Undefined: collision is tied to 0 and no overlap logic is built.

Test Plan:
- Reset mid-FETCH (assert at col=7) -> busy=0, pix_on=0, bm_xin=0; no sprite displayed on the next line until a new line_start.
- Sprite0 y=20, x=40, dir=1, line_start with vpos=19 -> 17 fetch cycles for sprite0 with bm_yin=0; bm_xin steps 0..15. Next line shows pix_on at hpos 40..55 matching the ROM row, pix_id=0, one-cycle latency.
- Sprites 0 and 2 both at x=40, y=20 -> pix_id=0 wherever both are set; with SPRITE_COLLISION_EN, collision=1 until the next frame_start.
- ANIM_FRAMES=8: 8 frame_start pulses -> bm_anim 0->1; 16 pulses -> back to 0.
- line_start at cycle 30 of a 4-sprite fetch -> overrun pulse, restart at i=0, busy held high for another 69 cycles.
- Sprite y=250, fetch vpos=265 (dy=15) -> last row fetched (bm_yin=15); vpos=266 -> no fetch; sprite x=250 -> displayed through hpos 265.

Source files
------------

// File: rtl/ghost_sprite_scheduler.sv
// ghost_sprite_scheduler: shares one ghost bitmap ROM between NUM_SPRITES ghosts.
// Each ghost's next-scanline row is fetched into a line buffer during hblank,
// and the prioritised ghost pixel is output during active video.
// Optional macro SPRITE_COLLISION_EN builds a sticky ghost-overlap flag;
// when it is undefined, collision is tied to 0.
module ghost_sprite_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int ANIM_FRAMES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [8:0]               hpos,
  input  logic [8:0]               vpos,
  input  logic                     line_start,
  input  logic                     frame_start,
  input  logic [8*NUM_SPRITES-1:0] sprite_x,
  input  logic [8*NUM_SPRITES-1:0] sprite_y,
  input  logic [2*NUM_SPRITES-1:0] sprite_dir,
  output logic                     bm_anim,
  output logic [1:0]               bm_dir,
  output logic [3:0]               bm_yin,
  output logic [3:0]               bm_xin,
  input  logic                     bm_bit,
  output logic                     pix_on,
  output logic [1:0]               pix_id,
  output logic                     busy,
  output logic                     overrun,
  output logic                     collision
);
  localparam int CW = ANIM_FRAMES > 1 ? $clog2(ANIM_FRAMES) : 1;
  typedef enum logic [1:0] {IDLE, CHECK, FETCH, NEXT} state_t;
  state_t                       state;
  logic [1:0]                   idx;
  logic [8:0]                   fline;
  logic [NUM_SPRITES-1:0]       valid;
  logic [NUM_SPRITES-1:0][15:0] linebuf;
  logic                         anim;
  logic [CW-1:0]                acnt;
  logic [7:0]                   cur_y;
  logic [1:0]                   cur_dir;
  logic [8:0]                   dy;
  logic                         hit;
  logic                         last;
  logic [NUM_SPRITES-1:0]       on_v;
  logic [NUM_SPRITES-1:0][8:0]  dx;
  logic [1:0]                   win_id;
  assign bm_anim = anim;
  assign cur_y   = sprite_y[{idx, 3'b000} +: 8];
  assign cur_dir = sprite_dir[{idx, 1'b0} +: 2];
  assign dy      = fline - {1'b0, cur_y};
  assign hit     = fline >= {1'b0, cur_y} && dy < 9'd16;
  assign last    = idx == 2'(NUM_SPRITES - 1);
  // animation state toggles once every ANIM_FRAMES frames
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acnt <= '0;
      anim <= 1'b0;
    end else if (frame_start) begin
      acnt <= acnt == CW'(ANIM_FRAMES - 1) ? '0 : acnt + 1'b1;
      anim <= acnt == CW'(ANIM_FRAMES - 1) ? ~anim : anim;
    end
  end
  // hblank fetch sequencer: walks the ghosts, copying each visible row out of the ROM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      fline   <= '0;
      valid   <= '0;
      linebuf <= '0;
      bm_dir  <= '0;
      bm_yin  <= '0;
      bm_xin  <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= line_start && state != IDLE;
      if (line_start) begin
        fline <= vpos + 9'd1;
        valid <= '0;
        idx   <= '0;
        state <= CHECK;
        busy  <= 1'b1;
      end else begin
        case (state)
          CHECK: begin
            if (hit) begin
              bm_dir <= cur_dir;
              bm_yin <= dy[3:0];
              bm_xin <= 4'd0;
              state  <= FETCH;
            end else if (last) begin
              state <= NEXT;
            end else begin
              idx <= idx + 2'd1;
            end
          end
          FETCH: begin
            linebuf[idx][bm_xin] <= bm_bit;
            bm_xin <= bm_xin + 4'd1;
            if (bm_xin == 4'd15) begin
              valid[idx] <= 1'b1;
              state      <= last ? NEXT : CHECK;
              idx        <= last ? idx : idx + 2'd1;
            end
          end
          NEXT: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end
  // per-ghost hit test at the current column, lowest index wins
  always_comb begin
    on_v   = '0;
    dx     = '0;
    win_id = '0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      dx[s]   = hpos - {1'b0, sprite_x[8*s +: 8]};
      on_v[s] = valid[s] && hpos >= {1'b0, sprite_x[8*s +: 8]} && dx[s] < 9'd16 && linebuf[s][dx[s][3:0]];
    end
    for (int s = NUM_SPRITES - 1; s >= 0; s--)
      win_id = on_v[s] ? 2'(s) : win_id;
  end
  // registered pixel output, one cycle behind hpos
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_on <= 1'b0;
      pix_id <= '0;
    end else begin
      pix_on <= |on_v;
      pix_id <= win_id;
    end
  end
`ifdef SPRITE_COLLISION_EN
  logic multi;
  assign multi = (on_v & (on_v - 1'b1)) != '0;
  // sticky overlap flag; a new overlap beats the frame clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) collision <= 1'b0;
    else       collision <= multi ? 1'b1 : frame_start ? 1'b0 : collision;
  end
`else
  assign collision = 1'b0;
`endif
endmodule

// File: tb/tb_ghost_sprite_scheduler.sv
// tb_ghost_sprite_scheduler: scoreboard bench for ghost_sprite_scheduler with a behavioural ROM
module tb_ghost_sprite_scheduler;
  localparam int N = 4;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic [8:0] hpos = 0, vpos = 0;
  logic line_start = 0, frame_start = 0;
  logic [8*N-1:0] sprite_x = '0, sprite_y = '0;
  logic [2*N-1:0] sprite_dir = '0;
  logic bm_anim, bm_bit, pix_on, busy, overrun, collision;
  logic [1:0] bm_dir, pix_id;
  logic [3:0] bm_yin, bm_xin;
  ghost_sprite_scheduler dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos), .line_start(line_start),
    .frame_start(frame_start), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_dir(sprite_dir), .bm_anim(bm_anim), .bm_dir(bm_dir), .bm_yin(bm_yin),
    .bm_xin(bm_xin), .bm_bit(bm_bit), .pix_on(pix_on), .pix_id(pix_id), .busy(busy),
    .overrun(overrun), .collision(collision));
  typedef struct packed {logic on; logic [1:0] id; logic col;} pix_t;
  pix_t sb[$];
  int n_cmp = 0, n_bad = 0;
  logic [N-1:0] mvalid = '0;
  logic [15:0] mrow [N];
  logic manim = 0, mcol = 0;
  int mcnt = 0;
  function automatic logic rom(logic a, logic [1:0] d, logic [3:0] y, logic [3:0] x);
    return (x[0] ^ y[1] ^ d[0] ^ a) | (x[2] & x[1]) | (x == 4'(y + 4'(d)));
  endfunction
  assign bm_bit = rom(bm_anim, bm_dir, bm_yin, bm_xin);
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_spr(int s, int x, int y, int d);
    sprite_x[8*s +: 8] = 8'(x);
    sprite_y[8*s +: 8] = 8'(y);
    sprite_dir[2*s +: 2] = 2'(d);
  endtask
  task automatic model_line(int fl);
    for (int s = 0; s < N; s++) begin
      int y, dyv;
      y = int'(sprite_y[8*s +: 8]);
      dyv = fl - y;
      mvalid[s] = fl >= y && dyv < 16;
      for (int c = 0; c < 16; c++) mrow[s][c] = rom(manim, sprite_dir[2*s +: 2], 4'(dyv), 4'(c));
    end
  endtask
  task automatic wait_busy(output int n);
    n = 0;
    while (busy && n < 300) begin
      n++;
      tick();
    end
  endtask
  task automatic line(int v, int exp_len);
    int n;
    vpos = 9'(v);
    line_start = 1;
    tick();
    line_start = 0;
    wait_busy(n);
    chk("busy_len", n, exp_len);
    model_line((v + 1) % 512);
  endtask
  task automatic frame();
    frame_start = 1;
    tick();
    frame_start = 0;
    if (mcnt == 7) begin
      mcnt = 0;
      manim = ~manim;
    end else mcnt++;
    mcol = 0;
    chk("bm_anim", bm_anim, manim);
    chk("coll_clr", collision, mcol);
  endtask
  task automatic scan(int lo, int hi);
    for (int h = lo; h <= hi; h++) begin
      pix_t e, g;
      int cnt;
      e = '0;
      cnt = 0;
      hpos = 9'(h);
      for (int s = N - 1; s >= 0; s--) begin
        int dxv;
        dxv = h - int'(sprite_x[8*s +: 8]);
        if (mvalid[s] && dxv >= 0 && dxv < 16 && mrow[s][dxv]) begin
          e.on = 1;
          e.id = 2'(s);
          cnt++;
        end
      end
`ifdef SPRITE_COLLISION_EN
      if (cnt > 1) mcol = 1;
`endif
      e.col = mcol;
      sb.push_back(e);
      tick();
      g = sb.pop_front();
      chk($sformatf("pix_on@%0d", h), pix_on, g.on);
      chk($sformatf("pix_id@%0d", h), pix_id, g.id);
      chk($sformatf("coll@%0d", h), collision, g.col);
    end
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_pix_on", pix_on, 0);
    chk("rst_pix_id", pix_id, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_anim", bm_anim, 0);
    chk("rst_xin", bm_xin, 0);
    chk("rst_coll", collision, 0);
    reset = 0;
    tick();
    set_spr(0, 40, 20, 1);
    set_spr(1, 100, 200, 2);
    set_spr(2, 40, 100, 3);
    set_spr(3, 150, 150, 0);
    vpos = 19;
    line_start = 1;
    tick();
    line_start = 0;
    chk("busy_check", busy, 1);
    tick();
    chk("fetch_yin", bm_yin, 0);
    chk("fetch_dir", bm_dir, 1);
    chk("fetch_xin0", bm_xin, 0);
    for (int c = 1; c < 16; c++) begin
      tick();
      chk("fetch_xin", bm_xin, c);
    end
    tick();
    wait_busy(n);
    chk("busy_len1", 17 + n, 21);
    model_line(20);
    scan(36, 60);
    set_spr(2, 40, 20, 3);
    line(19, 37);
    scan(36, 60);
    hpos = 0;
    for (int k = 0; k < 8; k++) frame();
    line(19, 37);
    scan(36, 60);
    hpos = 0;
    for (int k = 0; k < 8; k++) frame();
    set_spr(0, 40, 20, 0);
    set_spr(1, 80, 20, 1);
    set_spr(2, 120, 20, 2);
    set_spr(3, 160, 20, 3);
    vpos = 19;
    line_start = 1;
    tick();
    line_start = 0;
    repeat (29) tick();
    chk("pre_overrun", overrun, 0);
    line_start = 1;
    tick();
    line_start = 0;
    chk("overrun", overrun, 1);
    chk("overrun_busy", busy, 1);
    tick();
    chk("overrun_pulse", overrun, 0);
    wait_busy(n);
    chk("restart_len", 1 + n, 69);
    model_line(20);
    scan(36, 180);
    set_spr(0, 250, 250, 2);
    for (int s = 1; s < N; s++) set_spr(s, 0, 0, 0);
    vpos = 264;
    line_start = 1;
    tick();
    line_start = 0;
    tick();
    chk("last_row_yin", bm_yin, 15);
    wait_busy(n);
    chk("last_row_len", 1 + n, 21);
    model_line(265);
    scan(245, 270);
    line(265, 5);
    scan(248, 256);
    set_spr(0, 40, 20, 1);
    vpos = 19;
    line_start = 1;
    tick();
    line_start = 0;
    repeat (8) tick();
    chk("mid_xin", bm_xin, 7);
    reset = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_pix_on", pix_on, 0);
    chk("arst_xin", bm_xin, 0);
    tick();
    reset = 0;
    mvalid = '0;
    manim = 0;
    mcnt = 0;
    mcol = 0;
    scan(36, 60);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
